// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : CP0 exception / ERET sequencer. Accepts an exception, interrupt
//            or ERET in IDLE, performs the CP0 register writes one per cycle,
//            then flushes and redirects the pipeline.
//            Optional macro EXC_BADVADDR_EN adds the BadVAddr (8/0) write for
//            AdEL/AdES exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_req,
  input  logic [5:0]  int_pending,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  output logic [4:0]  cp0_addrW,
  output logic [5:0]  cp0_selW,
  output logic [31:0] cp0_din,
  output logic        cp0_write,
  output logic        busy,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_EPC    = 3'd1;
  localparam logic [2:0] S_WR_CAUSE  = 3'd2;
  localparam logic [2:0] S_WR_STATUS = 3'd3;
`ifdef EXC_BADVADDR_EN
  localparam logic [2:0] S_WR_BADV   = 3'd4;
`endif
  localparam logic [2:0] S_ERET      = 3'd5;
  localparam logic [2:0] S_REDIR     = 3'd6;

  logic [2:0]  state, state_nxt;

  // Latched request context, frozen for the duration of a sequence
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] status_q;
  logic [5:0]  ip_q;
  logic        eret_q;
  logic [31:0] epc_q;
`ifdef EXC_BADVADDR_EN
  logic [31:0] badv_q;
`else
  logic        unused_badv;
  assign unused_badv = ^exc_badvaddr;
`endif

  logic        int_cond;
  logic        take_exc;
  logic [31:0] epc_val;

  // Interrupt only when enabled, not at exception level, and an unmasked line is up
  assign int_cond = status[0] & ~status[1] & (|(int_pending & status[15:10]));
  assign take_exc = exc_req | int_cond;
  assign epc_val  = bd_q ? (pc_q - 32'd4) : pc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (take_exc)      state_nxt = S_WR_EPC;
        else if (eret_req) state_nxt = S_ERET;
        else               state_nxt = S_IDLE;
      end
      S_WR_EPC:    state_nxt = S_WR_CAUSE;
      S_WR_CAUSE:  state_nxt = S_WR_STATUS;
`ifdef EXC_BADVADDR_EN
      S_WR_STATUS: state_nxt = ((code_q == 5'd4) || (code_q == 5'd5)) ? S_WR_BADV : S_REDIR;
      S_WR_BADV:   state_nxt = S_REDIR;
`else
      S_WR_STATUS: state_nxt = S_REDIR;
`endif
      S_ERET:      state_nxt = S_REDIR;
      S_REDIR:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Capture request context on acceptance; capture EPC while in ERET_ST
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      pc_q     <= '0;
      bd_q     <= 1'b0;
      status_q <= '0;
      ip_q     <= '0;
      eret_q   <= 1'b0;
      epc_q    <= '0;
`ifdef EXC_BADVADDR_EN
      badv_q   <= '0;
`endif
    end else begin
      if (state == S_IDLE && (take_exc || eret_req)) begin
        code_q   <= exc_req ? exc_code : 5'd0;
        pc_q     <= exc_pc;
        bd_q     <= exc_bd;
        status_q <= status;
        ip_q     <= int_pending;
        eret_q   <= ~take_exc;
`ifdef EXC_BADVADDR_EN
        badv_q   <= exc_badvaddr;
`endif
      end
      if (state == S_ERET) epc_q <= epc;
    end
  end

  // Moore output decode from state and latched context
  always_comb begin
    cp0_addrW   = 5'd0;
    cp0_selW    = 6'd0;
    cp0_din     = 32'd0;
    cp0_write   = 1'b0;
    busy        = (state != S_IDLE);
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      S_WR_EPC: begin
        cp0_write = 1'b1;
        cp0_addrW = 5'd14;
        cp0_din   = epc_val;
      end
      S_WR_CAUSE: begin
        cp0_write = 1'b1;
        cp0_addrW = 5'd13;
        cp0_din   = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
      end
      S_WR_STATUS: begin
        cp0_write = 1'b1;
        cp0_addrW = 5'd12;
        cp0_din   = status_q | 32'h2;
      end
`ifdef EXC_BADVADDR_EN
      S_WR_BADV: begin
        cp0_write = 1'b1;
        cp0_addrW = 5'd8;
        cp0_din   = badv_q;
      end
`endif
      S_ERET: begin
        cp0_write = 1'b1;
        cp0_addrW = 5'd12;
        cp0_din   = status_q & ~32'h2;
      end
      S_REDIR: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = eret_q ? epc_q : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Directed, table-driven bench for exc_ctrl. Vectors run
//            back-to-back; garbage is driven on the inputs while busy.
//            Expected values follow EXC_BADVADDR_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

`ifdef EXC_BADVADDR_EN
  localparam bit BADV = 1'b1;
`else
  localparam bit BADV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_req;
  logic [5:0]  int_pending;
  logic [31:0] status;
  logic [31:0] epc;
  logic [4:0]  cp0_addrW;
  logic [5:0]  cp0_selW;
  logic [31:0] cp0_din;
  logic        cp0_write;
  logic        busy;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  exc_ctrl #(.EXC_VECTOR(32'h8000_0180)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret_req(eret_req), .int_pending(int_pending),
    .status(status), .epc(epc),
    .cp0_addrW(cp0_addrW), .cp0_selW(cp0_selW), .cp0_din(cp0_din), .cp0_write(cp0_write),
    .busy(busy), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             exc_req;
    logic [4:0]       code;
    logic [31:0]      pc;
    logic             bd;
    logic [31:0]      badv;
    logic             eret;
    logic [5:0]       ip;
    logic [31:0]      status;
    logic [31:0]      epc;
    int               nw;
    logic [3:0][4:0]  wa;
    logic [3:0][31:0] wd;
    int               redir_at;
    logic [31:0]      rpc;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] VEC = 32'h8000_0180;

  task automatic add_vec(input logic ex, input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic [31:0] badv, input logic er,
                         input logic [5:0] ip, input logic [31:0] st, input logic [31:0] ep,
                         input int nw,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2,
                         input logic [4:0] a3, input logic [31:0] d3,
                         input int redir_at, input logic [31:0] rpc);
    vec_t v;
    v.exc_req = ex; v.code = code; v.pc = pc; v.bd = bd; v.badv = badv; v.eret = er;
    v.ip = ip; v.status = st; v.epc = ep; v.nw = nw;
    v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1;
    v.wa[2] = a2; v.wd[2] = d2; v.wa[3] = a3; v.wd[3] = d3;
    v.redir_at = redir_at; v.rpc = rpc;
    vecs.push_back(v);
  endtask

  // {busy, flush, redirect, cp0_write, addr, sel, din, redirect_pc}
  task automatic check(input string nm, input logic [78:0] exp);
    logic [78:0] act;
    act = {busy, flush, redirect, cp0_write, cp0_addrW, cp0_selW, cp0_din, redirect_pc};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_req = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    eret_req = 1'b0; int_pending = '0; status = '0; epc = '0;
  endtask

  task automatic junk_inputs();
    exc_req = 1'b1; exc_code = 5'd3; exc_pc = 32'hDEAD_BEEF; exc_bd = 1'b1;
    exc_badvaddr = 32'hCAFE_F00D; eret_req = 1'b1; int_pending = 6'h3F; status = 32'hFFFF_FFFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    exc_req = v.exc_req; exc_code = v.code; exc_pc = v.pc; exc_bd = v.bd;
    exc_badvaddr = v.badv; eret_req = v.eret; int_pending = v.ip; status = v.status; epc = v.epc;
  endtask

  // Called at posedge+1 with the DUT in IDLE and inputs idle
  task automatic run_vec(input vec_t v, input int idx);
    int lim;
    logic [78:0] exp;
    lim = (v.redir_at == 0) ? 2 : v.redir_at + 1;
    apply_vec(v);
    for (int k = 1; k <= lim; k++) begin
      step();
      if (k <= v.nw)
        exp = {4'b1001, v.wa[k-1], 6'd0, v.wd[k-1], 32'd0};
      else if (k == v.redir_at)
        exp = {4'b1110, 5'd0, 6'd0, 32'd0, v.rpc};
      else
        exp = '0;
      check($sformatf("v%0d_cyc%0d", idx, k), exp);
      if (k < v.redir_at) junk_inputs();
      else                clear_inputs();
    end
  endtask

  initial begin
    int nwx, rdx;
    vec_t v1;
    nwx = BADV ? 4 : 3;
    rdx = BADV ? 5 : 4;

    //       ex code   pc            bd badv          er ip        status        epc
    add_vec(1, 5'd12, 32'h0040_0010, 0, 32'h0,        0, 6'd0,     32'h0000_0000, 32'h0,
            3, 14, 32'h0040_0010, 13, 32'h0000_0030, 12, 32'h0000_0002, 0, 32'h0, 4, VEC);
    add_vec(1, 5'd4,  32'h0040_0020, 1, 32'h0000_0003, 0, 6'd0,    32'h0000_0000, 32'h0,
            nwx, 14, 32'h0040_001C, 13, 32'h8000_0010, 12, 32'h0000_0002, 8, 32'h0000_0003, rdx, VEC);
    add_vec(0, 5'd0,  32'h0040_0040, 0, 32'h0,        0, 6'b000001, 32'h0000_0401, 32'h0,
            3, 14, 32'h0040_0040, 13, 32'h0000_0400, 12, 32'h0000_0403, 0, 32'h0, 4, VEC);
    add_vec(0, 5'd0,  32'h0040_0040, 0, 32'h0,        0, 6'b000001, 32'h0000_0403, 32'h0,
            0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    add_vec(0, 5'd0,  32'h0,         0, 32'h0,        1, 6'd0,     32'h0000_0003, 32'h0040_0100,
            1, 12, 32'h0000_0001, 0, 32'h0, 0, 32'h0, 0, 32'h0, 2, 32'h0040_0100);
    add_vec(1, 5'd12, 32'h0040_0010, 0, 32'h0,        1, 6'd0,     32'h0000_0000, 32'h0040_0100,
            3, 14, 32'h0040_0010, 13, 32'h0000_0030, 12, 32'h0000_0002, 0, 32'h0, 4, VEC);
    add_vec(1, 5'd5,  32'h0040_0080, 0, 32'h1234_5678, 0, 6'd0,    32'h0000_FF01, 32'h0,
            nwx, 14, 32'h0040_0080, 13, 32'h0000_0014, 12, 32'h0000_FF03, 8, 32'h1234_5678, rdx, VEC);
    add_vec(0, 5'd0,  32'h0040_0040, 0, 32'h0,        0, 6'b000001, 32'h0000_0400, 32'h0,
            0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    add_vec(1, 5'd8,  32'h0040_0004, 1, 32'h0,        0, 6'b100100, 32'h0000_0000, 32'h0,
            3, 14, 32'h0040_0000, 13, 32'h8000_9020, 12, 32'h0000_0002, 0, 32'h0, 4, VEC);
    add_vec(1, 5'd0,  32'h0000_0000, 1, 32'h0,        0, 6'd0,     32'h0000_0000, 32'h0,
            3, 14, 32'hFFFF_FFFC, 13, 32'h8000_0000, 12, 32'h0000_0002, 0, 32'h0, 4, VEC);
    add_vec(0, 5'd0,  32'h0040_0200, 0, 32'h0,        1, 6'b000010, 32'h0000_0801, 32'h0040_0100,
            3, 14, 32'h0040_0200, 13, 32'h0000_0800, 12, 32'h0000_0803, 0, 32'h0, 4, VEC);
    add_vec(0, 5'd0,  32'h0040_0200, 0, 32'h0,        0, 6'b000001, 32'h0000_0801, 32'h0,
            0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    add_vec(0, 5'd0,  32'h0,         0, 32'h0,        1, 6'd0,     32'h0000_FF13, 32'h0040_0500,
            1, 12, 32'h0000_FF11, 0, 32'h0, 0, 32'h0, 0, 32'h0, 2, 32'h0040_0500);
    add_vec(1, 5'd10, 32'h0040_0300, 0, 32'h0,        0, 6'd0,     32'h0000_0000, 32'h0,
            3, 14, 32'h0040_0300, 13, 32'h0000_0028, 12, 32'h0000_0002, 0, 32'h0, 4, VEC);

    // Reset with requests asserted: outputs must stay quiet
    rst = 1'b1;
    junk_inputs();
    epc = 32'h1111_2222;
    step(); step(); step();
    check("reset_hold", '0);
    clear_inputs();
    rst = 1'b0;
    step();
    check("reset_release", '0);

    // Vectors run back-to-back: each starts in the IDLE cycle after the previous REDIR
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset during WR_CAUSE aborts the sequence
    v1 = vecs[0];
    apply_vec(v1);
    step();
    check("abort_epc", {4'b1001, 5'd14, 6'd0, 32'h0040_0010, 32'd0});
    clear_inputs();
    step();
    check("abort_cause", {4'b1001, 5'd13, 6'd0, 32'h0000_0030, 32'd0});
    rst = 1'b1;
    step();
    check("abort_rst", '0);
    rst = 1'b0;
    step();
    check("abort_after1", '0);
    step();
    check("abort_after2", '0);
    step();
    check("abort_after3", '0);

    // Normal exception still works after the abort
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h8000_0180: exception handler entry PC.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 exc_req  input  1  exception pending from MEM stage, sampled only in IDLE.
REQ-005 exc_code  input  5  Cause.ExcCode of the pending exception.
REQ-006 exc_pc  input  32  PC of the faulting or interrupted instruction.
REQ-007 exc_bd  input  1  faulting instruction sits in a branch delay slot.
REQ-008 exc_badvaddr  input  32  faulting address, meaningful only for AdEL (4) and AdES (5).
REQ-009 eret_req  input  1  ERET retiring in MEM stage.
REQ-010 int_pending  input  6  hardware interrupt lines, level-sensitive.
REQ-011 status  input  32  live CP0 Status (12/0); bit0 IE, bit1 EXL, bits15:10 IM.
REQ-012 epc  input  32  live CP0 EPC (14/0).
REQ-013 cp0_addrW, cp0_selW, cp0_din, cp0_write  output  5/6/32/1  CP0 write port.
REQ-014 busy  output  1  pipeline stall; high in every non-IDLE state.
REQ-015 flush, redirect  output  1 each  pipeline flush and PC redirect strobes.
REQ-016 redirect_pc  output  32  new fetch PC, valid while redirect=1.

Function
REQ-017 FSM states: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, WR_BADV, ERET_ST, REDIR; all outputs decoded from the registered state and latched data (Moore).
REQ-018 IDLE priority: exc_req, then interrupt, then eret_req; a lower-priority request coincident with a higher one is dropped.
REQ-019 Interrupt condition: status[0]=1, status[1]=0, and (int_pending & status[15:10]) != 0; it is taken as exc_code 0 with EPC source exc_pc.
REQ-020 On entry from IDLE, latch code, pc, bd, badvaddr, status, and int_pending; inputs are ignored while busy=1.
REQ-021 Exception sequence: WR_EPC -> WR_CAUSE -> WR_STATUS -> [WR_BADV] -> REDIR -> IDLE, one cycle per state.
REQ-022 WR_EPC writes 14/0 = bd ? pc-4 : pc, modulo 2^32.
REQ-023 WR_CAUSE writes 13/0 = {bd, 15'b0, int_pending[5:0], 3'b0, code, 2'b0}.
REQ-024 WR_STATUS writes 12/0 = latched status | 32'h2.
REQ-025 WR_BADV writes 8/0 = badvaddr; the state is entered only when code is 4 or 5 and is otherwise skipped.
REQ-026 ERET sequence: ERET_ST writes 12/0 = status & ~32'h2 and samples epc; REDIR follows, then IDLE.
REQ-027 cp0_write=1 for exactly one cycle in each WR_* and ERET_ST state; otherwise 0, with cp0_addrW, cp0_selW, and cp0_din at 0.
REQ-028 In REDIR, flush=1 and redirect=1 for exactly one cycle; redirect_pc is EXC_VECTOR for exceptions or the sampled epc for ERET.
REQ-029 Latency from request cycle N to redirect: N+4 without BadVAddr, N+5 with it; ERET redirects at N+2.
REQ-030 An exception request in the cycle following REDIR is accepted normally (back-to-back).

Reset
REQ-031 rst=1 forces IDLE and clears all latched data; every output is 0 on the next cycle.
REQ-032 Reset mid-sequence aborts it; no further CP0 writes or redirects are issued.

Configuration
REQ-033 With EXC_BADVADDR_EN defined, WR_BADV exists per REQ-025.
REQ-034 Without EXC_BADVADDR_EN, WR_BADV is removed, exc_badvaddr is unused, and the AdEL/AdES exception sequence is identical to the other exception codes.

Verification
REQ-035 exc_req, code=12, pc=32'h0040_0010, bd=0 -> writes EPC 32'h0040_0010, then Cause 32'h0000_0030, then Status |2, then redirect_pc 32'h8000_0180 at N+4.
REQ-036 bd=1, pc=32'h0040_0020, code=4, badvaddr=32'h0000_0003, with EXC_BADVADDR_EN -> EPC 32'h0040_001C, Cause bit31=1, 8/0 = 32'h0000_0003, redirect at N+5; without the macro, redirect at N+4 and no 8/0 write.
REQ-037 status=32'h0000_0401, int_pending=6'b000001 -> interrupt taken with Cause 32'h0000_0400; with status=32'h0000_0403 -> nothing happens.
REQ-038 eret_req, epc=32'h0040_0100, status=32'h0000_0003 -> Status write 32'h0000_0001, then redirect_pc 32'h0040_0100 at N+2.
REQ-039 Simultaneous exc_req and eret_req -> exception sequence only; rst asserted during WR_CAUSE -> no Status write, no redirect, and all outputs 0.
